// File: rtl/runner_motion_ctrl_pkg.sv
// Shared movement codes, FSM state encoding and command helpers for the runner
// motion sequencer and the keyboard decoder that feeds it.
package runner_motion_ctrl_pkg;

  localparam logic [2:0] MV_NONE       = 3'b000;
  localparam logic [2:0] MV_JUMP_BIG   = 3'b001;
  localparam logic [2:0] MV_JUMP_SMALL = 3'b010;
  localparam logic [2:0] MV_CROUCH     = 3'b011;
  localparam logic [2:0] MV_DROP       = 3'b100;

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_RISE   = 3'd1,
    ST_FALL   = 3'd2,
    ST_DROP   = 3'd3
  } motion_state_e;

  // Pulse-type codes are the only ones worth remembering until the next frame.
  function automatic logic is_pulse_cmd(input logic [2:0] mv);
    return (mv == MV_JUMP_BIG) || (mv == MV_JUMP_SMALL) || (mv == MV_DROP);
  endfunction

  function automatic logic is_jump_cmd(input logic [2:0] mv);
    return (mv == MV_JUMP_BIG) || (mv == MV_JUMP_SMALL);
  endfunction

endpackage

// File: rtl/runner_motion_ctrl_if.sv
// Movement/frame inputs and sprite status outputs of the runner motion sequencer.
interface runner_motion_ctrl_if #(
  parameter int H_W = 8
);

  logic [2:0]     movement;
  logic           frame_tick;
  logic [H_W-1:0] height;
  logic           crouch;
  logic           airborne;
  logic           land;
  logic [2:0]     state_dbg;

  modport master (
    output movement,
    output frame_tick,
    input  height,
    input  crouch,
    input  airborne,
    input  land,
    input  state_dbg
  );

  modport slave (
    input  movement,
    input  frame_tick,
    output height,
    output crouch,
    output airborne,
    output land,
    output state_dbg
  );

endinterface

// File: rtl/runner_motion_ctrl_cmd_latch.sv
// Holds the most recent pulse command between frame ticks and presents the
// effective command, bypassing the register when a pulse arrives on the tick itself.
module motion_cmd_latch
  import runner_motion_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] movement,
  input  logic       frame_tick,
  output logic [2:0] eff_cmd
);

  logic [2:0] pending_q;
  logic [2:0] pending_d;
  logic       pulse_now;

  always_comb begin
    pulse_now = is_pulse_cmd(movement);
    eff_cmd   = pulse_now ? movement : pending_q;
    pending_d = pending_q;
    // Every tick empties the slot, whether the FSM used the command or not.
    if (frame_tick) begin
      pending_d = MV_NONE;
    end else if (pulse_now) begin
      pending_d = movement;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= MV_NONE;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/runner_motion_ctrl.sv
// Frame-rate motion sequencer: steps the runner's height through rise, fall and
// fast-drop arcs once per frame tick and reports crouch/airborne/landing status.
module runner_motion_ctrl
  import runner_motion_ctrl_pkg::*;
#(
  parameter int H_W       = 8,
  parameter int BIG_H     = 40,
  parameter int SMALL_H   = 20,
  parameter int RISE_STEP = 4,
  parameter int FALL_STEP = 4,
  parameter int DROP_STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  runner_motion_ctrl_if.slave  bus
);

  localparam logic [H_W-1:0] BIG_T   = BIG_H[H_W-1:0];
  localparam logic [H_W-1:0] SMALL_T = SMALL_H[H_W-1:0];
  localparam logic [H_W:0]   RISE_W  = RISE_STEP[H_W:0];
  localparam logic [H_W:0]   FALL_W  = FALL_STEP[H_W:0];
  localparam logic [H_W:0]   DROP_W  = DROP_STEP[H_W:0];

  motion_state_e  state_q, state_d;
  logic [H_W-1:0] height_q, height_d;
  logic [H_W-1:0] target_q, target_d;
  logic           crouch_q, crouch_d;
  logic           airborne_q, airborne_d;
  logic           land_q, land_d;

  logic [2:0]     eff_cmd;
  logic [H_W:0]   height_ext;
  logic [H_W:0]   rise_sum;

  motion_cmd_latch u_cmd_latch (
    .clk        (clk),
    .reset      (reset),
    .movement   (bus.movement),
    .frame_tick (bus.frame_tick),
    .eff_cmd    (eff_cmd)
  );

  // The extra top bit keeps the apex compare and the clamp tests free of wrap-around.
  assign height_ext = {1'b0, height_q};
  assign rise_sum   = height_ext + RISE_W;

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    target_d = target_q;
    crouch_d = crouch_q;
    land_d   = 1'b0;

    if (bus.frame_tick) begin
      case (state_q)
        ST_GROUND: begin
          if (is_jump_cmd(eff_cmd)) begin
            state_d  = ST_RISE;
            target_d = (eff_cmd == MV_JUMP_BIG) ? BIG_T : SMALL_T;
            crouch_d = 1'b0;
          end else if (eff_cmd != MV_DROP) begin
            crouch_d = (bus.movement == MV_CROUCH);
          end
        end

        ST_RISE: begin
          if (eff_cmd == MV_DROP) begin
            state_d = ST_DROP;
          end else if (rise_sum >= {1'b0, target_q}) begin
            height_d = target_q;
            state_d  = ST_FALL;
          end else begin
            height_d = rise_sum[H_W-1:0];
          end
        end

        ST_FALL: begin
          if (eff_cmd == MV_DROP) begin
            state_d = ST_DROP;
          end else if (height_ext <= FALL_W) begin
            height_d = '0;
            state_d  = ST_GROUND;
            land_d   = 1'b1;
          end else begin
            height_d = height_q - FALL_W[H_W-1:0];
          end
        end

        ST_DROP: begin
          if (height_ext <= DROP_W) begin
            height_d = '0;
            state_d  = ST_GROUND;
            land_d   = 1'b1;
          end else begin
            height_d = height_q - DROP_W[H_W-1:0];
          end
        end

        default: begin
          state_d  = ST_GROUND;
          height_d = '0;
          crouch_d = 1'b0;
        end
      endcase
    end

    airborne_d = (state_d != ST_GROUND);
  end

  // Reset drops the sprite straight to the ground; an interrupted arc never resumes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_GROUND;
      height_q   <= '0;
      target_q   <= '0;
      crouch_q   <= 1'b0;
      airborne_q <= 1'b0;
      land_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      height_q   <= height_d;
      target_q   <= target_d;
      crouch_q   <= crouch_d;
      airborne_q <= airborne_d;
      land_q     <= land_d;
    end
  end

  assign bus.height    = height_q;
  assign bus.crouch    = crouch_q;
  assign bus.airborne  = airborne_q;
  assign bus.land      = land_q;
  assign bus.state_dbg = state_q;

endmodule
